// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch-stage control FSM for hazard stalls, interrupt entry and load-use freezes.
// Optional bubble counter is built when FETCH_PERF_CNT_EN is defined.
module fetch_sequencer #(
    parameter int HAZ_MIN_BUBBLES = 2,
    parameter int INT_SEQ_CYCLES  = 3
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_int_req,
    input  logic        i_hazard_instr,
    input  logic        i_branch_resolved,
    input  logic        i_branch_taken,
    input  logic        i_load_use_stall,
    output logic        o_fetch_enable,
    output logic        o_insert_nop,
    output logic        o_interrupt_signal,
    output logic        o_flush_decode,
    output logic        o_int_ack,
    output logic [1:0]  o_state,
    output logic [15:0] o_bubble_count
);
    typedef enum logic [1:0] {IDLE = 2'd0, HAZ_WAIT = 2'd1, INT_ENTRY = 2'd2, INT_SEQ = 2'd3} state_t;

    state_t     state, state_next;
    logic [3:0] cnt, cnt_next;
    logic       resolved, resolved_next;
    logic       int_pending, int_req_d, ack_next;
    logic       int_rise, int_take;

    assign int_rise = i_int_req & ~int_req_d;
    assign int_take = (state == IDLE) && (state_next == INT_ENTRY);
    assign o_state  = state;

    // state, counter, flags; a new request edge outranks the clear on entry
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            resolved    <= 1'b0;
            int_pending <= 1'b0;
            int_req_d   <= 1'b0;
            o_int_ack   <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            resolved    <= resolved_next;
            int_pending <= int_rise | (int_pending & ~int_take);
            int_req_d   <= i_int_req;
            o_int_ack   <= ack_next;
        end
    end

    // next-state and fetch control outputs
    always_comb begin
        state_next         = state;
        cnt_next           = cnt;
        resolved_next      = resolved;
        ack_next           = 1'b0;
        o_fetch_enable     = 1'b1;
        o_insert_nop       = 1'b0;
        o_interrupt_signal = 1'b0;
        o_flush_decode     = 1'b0;
        case (state)
            IDLE: begin
                o_fetch_enable = ~i_load_use_stall;
                if (i_hazard_instr && !i_load_use_stall) begin
                    state_next    = HAZ_WAIT;
                    cnt_next      = 4'(HAZ_MIN_BUBBLES);
                    resolved_next = 1'b0;
                end else if (int_pending && !i_load_use_stall) begin
                    state_next = INT_ENTRY;
                end
            end
            HAZ_WAIT: begin
                o_fetch_enable = 1'b0;
                o_insert_nop   = 1'b1;
                o_flush_decode = i_branch_resolved & i_branch_taken;
                cnt_next       = (cnt != 4'd0) ? cnt - 4'd1 : 4'd0;
                resolved_next  = resolved | i_branch_resolved;
                if (cnt <= 4'd1 && (resolved || i_branch_resolved))
                    state_next = IDLE;
            end
            INT_ENTRY: begin
                o_insert_nop       = 1'b1;
                o_interrupt_signal = 1'b1;
                state_next         = INT_SEQ;
                cnt_next           = 4'(INT_SEQ_CYCLES);
            end
            INT_SEQ: begin
                o_fetch_enable = 1'b0;
                o_insert_nop   = 1'b1;
                cnt_next       = (cnt != 4'd0) ? cnt - 4'd1 : 4'd0;
                if (cnt == 4'd1) begin
                    state_next = IDLE;
                    ack_next   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] bubble_count;

    // saturating count of NOP-inserted cycles
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)
            bubble_count <= 16'h0000;
        else if (o_insert_nop && bubble_count != 16'hFFFF)
            bubble_count <= bubble_count + 16'd1;
    end

    assign o_bubble_count = bubble_count;
`else
    assign o_bubble_count = 16'h0000;
`endif
endmodule
